// File: rtl/rsa_pkg.sv
// rtl/rsa_pkg.sv - shared RSA256 datapath constants and prep-stage state encoding
package rsa_pkg;

  localparam int RSA_WIDTH = 256;
  localparam int RSA_CNT_W = 9;

  typedef enum logic [1:0] {
    PREP_IDLE   = 2'd0,
    PREP_REDUCE = 2'd1,
    PREP_SHIFT  = 2'd2,
    PREP_DONE   = 2'd3
  } prep_state_e;

endpackage

// File: rtl/rsa_mod_dbl.sv
// rtl/rsa_mod_dbl.sv - combinational ({x,in_bit} mod N), valid when x < N
module rsa_mod_dbl #(
  parameter int WIDTH = 256
) (
  input  logic [WIDTH-1:0] x,
  input  logic             in_bit,
  input  logic [WIDTH-1:0] N,
  output logic [WIDTH-1:0] r
);

  logic [WIDTH:0] s;
  logic           ge;

  // The compare is WIDTH+1 bits wide; the subtract can be truncated because
  // the true difference is always below N when x < N.
  always_comb begin
    s  = {x, in_bit};
    ge = (s >= {1'b0, N});
    r  = ge ? (s[WIDTH-1:0] - N) : s[WIDTH-1:0];
  end

endmodule

// File: rtl/rsa_mod_prep.sv
// rtl/rsa_mod_prep.sv - computes y*2^WIDTH mod N by repeated modular doubling
// Optional RSA_PREP_FULL_REDUCE_EN adds a bit-serial y mod N phase before the doubling.
module rsa_mod_prep
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH,
  parameter int CNT_W = RSA_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] N,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] m,
  output logic             finish,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  prep_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] t_q, t_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic             finish_q, finish_d;
  logic             dbl_bit;
  logic [WIDTH-1:0] dbl_out;
  logic             last_step;
`ifdef RSA_PREP_FULL_REDUCE_EN
  logic [WIDTH-1:0] y_q, y_d;
`endif

  assign last_step = (cnt_q == LAST_CNT);

  // Single doubler shared by the REDUCE and SHIFT phases.
  rsa_mod_dbl #(.WIDTH(WIDTH)) u_dbl (
    .x      (t_q),
    .in_bit (dbl_bit),
    .N      (n_q),
    .r      (dbl_out)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    t_d      = t_q;
    n_d      = n_q;
    m_d      = m_q;
    finish_d = 1'b0;
    dbl_bit  = 1'b0;
`ifdef RSA_PREP_FULL_REDUCE_EN
    y_d      = y_q;
`endif
    case (state_q)
      PREP_IDLE: begin
        if (start) begin
          n_d   = N;
          cnt_d = '0;
`ifdef RSA_PREP_FULL_REDUCE_EN
          t_d     = '0;
          y_d     = y;
          state_d = PREP_REDUCE;
`else
          t_d     = y;
          state_d = PREP_SHIFT;
`endif
        end
      end
`ifdef RSA_PREP_FULL_REDUCE_EN
      PREP_REDUCE: begin
        // y is consumed MSB first by shifting the latched copy left.
        dbl_bit = y_q[WIDTH-1];
        t_d     = dbl_out;
        y_d     = {y_q[WIDTH-2:0], 1'b0};
        cnt_d   = cnt_q + 1'b1;
        if (last_step) begin
          cnt_d   = '0;
          state_d = PREP_SHIFT;
        end
      end
`endif
      PREP_SHIFT: begin
        t_d   = dbl_out;
        cnt_d = cnt_q + 1'b1;
        if (last_step) begin
          m_d      = (n_q == '0) ? '0 : dbl_out;
          finish_d = 1'b1;
          state_d  = PREP_DONE;
        end
      end
      PREP_DONE: begin
        state_d = PREP_IDLE;
      end
      default: begin
        state_d = PREP_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= PREP_IDLE;
      cnt_q    <= '0;
      t_q      <= '0;
      n_q      <= '0;
      m_q      <= '0;
      finish_q <= 1'b0;
`ifdef RSA_PREP_FULL_REDUCE_EN
      y_q      <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      t_q      <= t_d;
      n_q      <= n_d;
      m_q      <= m_d;
      finish_q <= finish_d;
`ifdef RSA_PREP_FULL_REDUCE_EN
      y_q      <= y_d;
`endif
    end
  end

  assign m      = m_q;
  assign finish = finish_q;
  assign busy   = (state_q != PREP_IDLE);

endmodule

// File: tb/tb_rsa_mod_prep.sv
// tb/tb_rsa_mod_prep.sv - self-checking bench for rsa_mod_prep against an arithmetic reference
module tb_rsa_mod_prep;

`ifdef RSA_PREP_FULL_REDUCE_EN
  localparam int LAT = 513;
`else
  localparam int LAT = 257;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [255:0] N = '0;
  logic [255:0] y = '0;
  logic [255:0] m;
  logic         finish;
  logic         busy;

  int total = 0;
  int bad   = 0;

  rsa_mod_prep dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .N      (N),
    .y      (y),
    .m      (m),
    .finish (finish),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] ref_prep(input logic [255:0] n, input logic [255:0] yy);
    logic [511:0] num;
    logic [511:0] den;
    if (n == '0) return '0;
    num = {yy, 256'b0};
    den = {256'b0, n};
    return 256'(num % den);
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Reference: cycles remaining until finish, result pending and visible.
  int           rem = 0;
  logic [255:0] pend = '0;
  logic [255:0] exp_m = '0;
  bit           chk_en = 0;

  always @(posedge clk) begin
    if (rst) begin
      rem   <= 0;
      exp_m <= '0;
    end else if (rem == 0) begin
      if (start) begin
        rem  <= LAT;
        pend <= ref_prep(N, y);
      end
    end else begin
      rem <= rem - 1;
      if (rem == 2) exp_m <= pend;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_busy", {255'b0, busy}, {255'b0, rem != 0});
      chk("cyc_finish", {255'b0, finish}, {255'b0, rem == 1});
      chk("cyc_m", m, exp_m);
    end
  end

  task automatic run(input logic [255:0] nn, input logic [255:0] yy,
                     input logic [255:0] expv, input string name);
    int  k;
    bit  seen;
    bit  busy_ok;
    @(posedge clk); #1;
    N = nn; y = yy; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 0; busy_ok = 1; k = 0;
    for (int c = 1; c <= LAT + 10 && !seen; c++) begin
      if (!busy) busy_ok = 0;
      if (finish) begin
        seen = 1;
        k = c;
      end else begin
        @(posedge clk); #1;
      end
    end
    chk({name, "_seen"}, {255'b0, seen}, 256'd1);
    chk({name, "_lat"}, 256'(k), 256'(LAT));
    chk({name, "_busy"}, {255'b0, busy_ok}, 256'd1);
    chk({name, "_m"}, m, expv);
    @(posedge clk); #1;
    chk({name, "_idle"}, {255'b0, busy}, 256'd0);
  endtask

  logic [255:0] all1;
  int           f1, f2, nfin;

  initial begin
    all1 = '1;
    chk("pin_7_3", ref_prep(256'd7, 256'd3), 256'd6);
    chk("pin_11_4", ref_prep(256'd11, 256'd4), 256'd3);
    chk("pin_top", ref_prep(all1, all1 - 256'd1), all1 - 256'd1);
    chk("pin_n0", ref_prep(256'd0, 256'd5), 256'd0);

    @(posedge clk); #1;
    chk_en = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_m", m, 256'd0);
    chk("rst_finish", {255'b0, finish}, 256'd0);
    chk("rst_busy", {255'b0, busy}, 256'd0);

    run(256'd7, 256'd3, 256'd6, "n7_y3");
    run(256'd5, 256'd3, 256'd3, "n5_y3");
    run(all1, all1 - 256'd1, all1 - 256'd1, "top");
    run(256'd13, 256'd0, 256'd0, "y0");
    run(256'd0, 256'd5, 256'd0, "n0");
    run(256'd11, 256'd4, 256'd3, "n11_y4");

    // Start held high: back-to-back results, mid-run N/y changes ignored.
    @(posedge clk); #1;
    N = 256'd7; y = 256'd3; start = 1'b1;
    f1 = 0; f2 = 0;
    for (int c = 1; c <= 2 * LAT + 20 && f2 == 0; c++) begin
      @(posedge clk); #1;
      if (c == 50) begin N = 256'd5; y = 256'd1; end
      if (c == 200) begin N = 256'd7; y = 256'd3; end
      if (finish) begin
        chk("hold_m", m, 256'd6);
        if (f1 == 0) f1 = c;
        else begin
          f2 = c;
          start = 1'b0;
        end
      end
    end
    chk("hold_first", 256'(f1), 256'(LAT));
    chk("hold_second", 256'(f2), 256'(2 * LAT + 1));
    @(posedge clk); #1;

    // Reset in the middle of a run.
    @(posedge clk); #1;
    N = 256'd7; y = 256'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (99) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_m", m, 256'd0);
    chk("abort_finish", {255'b0, finish}, 256'd0);
    chk("abort_busy", {255'b0, busy}, 256'd0);
    nfin = 0;
    repeat (LAT + 50) begin
      @(posedge clk); #1;
      if (finish) nfin++;
    end
    chk("abort_no_finish", 256'(nfin), 256'd0);
    run(256'd7, 256'd3, 256'd6, "after_abort");

`ifdef RSA_PREP_FULL_REDUCE_EN
    run(256'd7, 256'd10, 256'd6, "red_7_10");
    run(256'd7, all1, 256'd2, "red_ones");
    chk("red_ones_model", m, ref_prep(256'd7, all1));
`endif

    @(negedge clk);
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout act=running exp=finished");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

endmodule
